// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap or saturate boundaries,
// registered terminal-count pulse and sticky overflow/underflow flags.
module updown_counter_param #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter bit               SAT_MODE = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ctrl,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic             at_max;
    logic             at_zero;
    logic             step;
    logic             up_ev;
    logic             dn_ev;
    logic [WIDTH-1:0] load_sat;
    logic [WIDTH-1:0] cnt_nxt;

    // Boundary detection against MAX_VAL so odd moduli are exact.
    always_comb begin
        at_max   = (out == MAX_VAL);
        at_zero  = (out == ZERO);
        step     = en & ~load;
        up_ev    = step & ctrl & at_max;
        dn_ev    = step & ~ctrl & at_zero;
        load_sat = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end

    // Next count: load beats count, count beats hold.
    always_comb begin
        cnt_nxt = out;
        if (load) begin
            cnt_nxt = load_sat;
        end else if (en) begin
            if (ctrl) begin
                if (at_max) cnt_nxt = SAT_MODE ? MAX_VAL : ZERO;
                else        cnt_nxt = out + ONE;
            end else begin
                if (at_zero) cnt_nxt = SAT_MODE ? ZERO : MAX_VAL;
                else         cnt_nxt = out - ONE;
            end
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) out <= RST_VAL;
        else      out <= cnt_nxt;
    end

    // Terminal-count pulse: high for each processed boundary event.
    always_ff @(posedge clk) begin
        if (!rst) tc <= 1'b0;
        else      tc <= up_ev | dn_ev;
    end

    // Sticky flags; a boundary event wins over a same-edge clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= (ovf & ~clr_flags) | up_ev;
            unf <= (unf & ~clr_flags) | dn_ev;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations driven in
// parallel, checked against an arithmetic reference model.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       ctrl = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       clr_flags = 1'b0;
    logic [3:0] o [3];
    logic       tcv [3];
    logic       ov [3];
    logic       un [3];

    int n_chk = 0;
    int n_fail = 0;

    int mx [3] = '{15, 9, 9};
    int sm [3] = '{0, 0, 1};
    int rv [3] = '{0, 0, 3};
    int m_out [3];
    int m_tc [3];
    int m_ovf [3];
    int m_unf [3];

    always #5 clk = ~clk;

    updown_counter_param #(
        .WIDTH(4), .MAX_VAL(4'd15),
        .SAT_MODE(1'b0), .RST_VAL(4'd0)
    ) u0 (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl),
        .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .out(o[0]),
        .tc(tcv[0]), .ovf(ov[0]), .unf(un[0])
    );

    updown_counter_param #(
        .WIDTH(4), .MAX_VAL(4'd9),
        .SAT_MODE(1'b0), .RST_VAL(4'd0)
    ) u1 (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl),
        .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .out(o[1]),
        .tc(tcv[1]), .ovf(ov[1]), .unf(un[1])
    );

    updown_counter_param #(
        .WIDTH(4), .MAX_VAL(4'd9),
        .SAT_MODE(1'b1), .RST_VAL(4'd3)
    ) u2 (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl),
        .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .out(o[2]),
        .tc(tcv[2]), .ovf(ov[2]), .unf(un[2])
    );

    task automatic chk(input string tag, input int got,
                       input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    // Reference model: count range 0..mx as plain integers.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int nx;
            int up_ev;
            int dn_ev;
            nx = m_out[i];
            up_ev = 0;
            dn_ev = 0;
            if (!rst) begin
                m_out[i] = rv[i];
                m_tc[i] = 0;
                m_ovf[i] = 0;
                m_unf[i] = 0;
            end else begin
                if (load) begin
                    nx = (int'(load_val) > mx[i]) ?
                         mx[i] : int'(load_val);
                end else if (en && ctrl) begin
                    up_ev = (m_out[i] + 1 > mx[i]) ? 1 : 0;
                    if (sm[i] == 1)
                        nx = up_ev ? mx[i] : m_out[i] + 1;
                    else
                        nx = (m_out[i] + 1) % (mx[i] + 1);
                end else if (en) begin
                    dn_ev = (m_out[i] - 1 < 0) ? 1 : 0;
                    if (sm[i] == 1)
                        nx = dn_ev ? 0 : m_out[i] - 1;
                    else
                        nx = (m_out[i] + mx[i]) % (mx[i] + 1);
                end
                m_out[i] = nx;
                m_tc[i] = up_ev | dn_ev;
                m_ovf[i] = (m_ovf[i] & ~int'(clr_flags)) | up_ev;
                m_unf[i] = (m_unf[i] & ~int'(clr_flags)) | dn_ev;
            end
        end
    endtask

    // Apply one cycle of inputs, advance model, compare all outputs.
    task automatic cyc(input logic r, input logic e,
                       input logic c, input logic l,
                       input int lv, input logic cf);
        rst = r;
        en = e;
        ctrl = c;
        load = l;
        load_val = 4'(lv);
        clr_flags = cf;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("m%0d_out", i), o[i], m_out[i]);
            chk($sformatf("m%0d_tc", i), tcv[i], m_tc[i]);
            chk($sformatf("m%0d_ovf", i), ov[i], m_ovf[i]);
            chk($sformatf("m%0d_unf", i), un[i], m_unf[i]);
        end
    endtask

    int dexp [4] = '{1, 0, 9, 8};
    int sexp [5] = '{8, 9, 9, 9, 9};

    initial begin
        // reset then count up through the 15->0 wrap
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 7, 1);
        chk("rst_out0", o[0], 0);
        chk("rst_out2", o[2], 3);
        chk("rst_ovf0", ov[0], 0);
        chk("rst_tc0", tcv[0], 0);
        for (int k = 0; k < 17; k++) begin
            cyc(1, 1, 1, 0, 0, 0);
            chk("up_out", o[0], (k + 1) % 16);
            chk("up_tc", tcv[0], int'(k == 15));
            chk("up_ovf", ov[0], int'(k >= 15));
        end

        // decade down-count through 0->9
        cyc(1, 0, 0, 1, 2, 0);
        chk("dec_load", o[1], 2);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 0, 0, 0, 0);
            chk("dec_out", o[1], dexp[k]);
            chk("dec_tc", tcv[1], int'(k == 2));
        end
        chk("dec_unf", un[1], 1);
        cyc(1, 0, 0, 1, 12, 0);
        chk("clamp9", o[1], 9);
        chk("noclamp15", o[0], 12);

        // saturate at 9 and at 0
        cyc(1, 0, 0, 1, 7, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 1, 0, 0, 0);
            chk("sat_out", o[2], sexp[k]);
            chk("sat_tc", tcv[2], int'(k >= 2));
        end
        chk("sat_ovf", ov[2], 1);
        cyc(1, 0, 0, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("sat_dn0", o[2], 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("sat_dn1", o[2], 0);
        chk("sat_unf", un[2], 1);

        // priority: load over count, reset over load, hold
        cyc(1, 0, 0, 1, 3, 0);
        cyc(1, 1, 1, 1, 5, 0);
        chk("ld_over_en", o[0], 5);
        chk("ld_no_tc", tcv[0], 0);
        cyc(0, 1, 1, 1, 5, 1);
        chk("rst_over_ld", o[2], 3);
        chk("rst_over_ld0", o[0], 0);
        cyc(1, 0, 0, 1, 6, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 1, 0, 0, 0);
            chk("hold_out", o[0], 6);
            chk("hold_tc", tcv[0], 0);
        end

        // flag clear race with wrap
        cyc(1, 0, 0, 1, 15, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("wrap_ovf", ov[0], 1);
        cyc(1, 0, 0, 0, 0, 1);
        chk("clr_ovf", ov[0], 0);
        cyc(1, 0, 0, 1, 15, 0);
        cyc(1, 1, 1, 0, 0, 1);
        chk("race_ovf", ov[0], 1);
        chk("race_out", o[0], 0);

        // direction flip and mid-run reset
        cyc(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 1, 0, 0, 0);
            chk("flip_up", o[0], k + 1);
        end
        cyc(1, 1, 0, 0, 0, 0);
        chk("flip_dn4", o[0], 4);
        cyc(1, 1, 0, 0, 0, 0);
        chk("flip_dn3", o[0], 3);
        cyc(0, 1, 1, 0, 0, 0);
        chk("mid_rst", o[0], 0);
        chk("mid_rst_ovf", ov[0], 0);
        chk("mid_rst_unf", un[0], 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("resume", o[0], 1);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(31) != 0,
                $urandom_range(3) != 0,
                1'($urandom),
                $urandom_range(7) == 0,
                int'($urandom_range(15)),
                $urandom_range(15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
